// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory bridge.
package dmem_pkg;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } width_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  // An access is illegal if its width is reserved or its address is not
  // naturally aligned to that width.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] offs);
    case (width)
      WIDTH_BYTE: return 1'b0;
      WIDTH_HALF: return offs[0];
      WIDTH_WORD: return (offs != 2'b00);
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// RAM-side valid/ready bus of the data-memory bridge.
interface dmem_bridge_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store strobes, store-data replication and load shift.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  req_offset,
  input  logic [31:0] store_data,
  input  logic [1:0]  rsp_offset,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  // Strobes and replicated data follow the requested width and lane.
  always_comb begin
    wstrb = 4'b0000;
    wdata = store_data;
    case (width)
      WIDTH_BYTE: begin
        wstrb = 4'b0001 << req_offset;
        wdata = {4{store_data[7:0]}};
      end
      WIDTH_HALF: begin
        wstrb = 4'b0011 << req_offset;
        wdata = {2{store_data[15:0]}};
      end
      WIDTH_WORD: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
      default: begin
        wstrb = 4'b0000;
        wdata = store_data;
      end
    endcase
  end

  // Load data is right-justified by the latched byte offset; no sign extension.
  always_comb begin
    rdata = load_word >> {rsp_offset, 3'b000};
  end

endmodule

// File: rtl/dmem_bridge.sv
// Core data port to valid/ready RAM bridge with stall, lane alignment and
// misalignment detection. Optional hung-transaction abort is enabled by
// defining DMEM_TIMEOUT_EN.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        req_address,
  input  logic [31:0]        req_write_data,
  input  logic               req_read_enable,
  input  logic               req_write_enable,
  input  logic [1:0]         req_width,
  output logic               stall,
  output logic [31:0]        resp_read_data,
  output logic               misaligned,
  output logic               bus_error,
  dmem_bridge_if.master      mem
);

  state_e      state, state_nxt;
  logic        request;
  logic        illegal;
  logic        tmo;

  logic [29:0] addr_p0;
  logic [1:0]  offset_p0;
  logic        we_p0;
  logic [31:0] wdata_p0;
  logic [3:0]  wstrb_p0;
  logic        mis_p0;
  logic [31:0] resp_p0;

  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign request = req_read_enable | req_write_enable;
  assign illegal = is_misaligned(req_width, req_address[1:0]);

  dmem_lane_align u_lane_align (
    .width      (req_width),
    .req_offset (req_address[1:0]),
    .store_data (req_write_data),
    .rsp_offset (offset_p0),
    .load_word  (mem.mem_rdata),
    .wstrb      (lane_wstrb),
    .wdata      (lane_wdata),
    .rdata      (lane_rdata)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; completion wins over a timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (request) state_nxt = illegal ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        if (mem.mem_ready) state_nxt = we_p0 ? ST_DONE : ST_WAIT_RESP;
        else if (tmo)      state_nxt = ST_DONE;
      end
      ST_WAIT_RESP: begin
        if (mem.mem_rvalid) state_nxt = ST_DONE;
        else if (tmo)       state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture in IDLE and response capture in WAIT_RESP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_p0   <= '0;
      offset_p0 <= '0;
      we_p0     <= 1'b0;
      wdata_p0  <= '0;
      wstrb_p0  <= '0;
      mis_p0    <= 1'b0;
      resp_p0   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (request) begin
            mis_p0 <= illegal;
            if (illegal) begin
              resp_p0 <= '0;
            end else begin
              addr_p0   <= req_address[31:2];
              offset_p0 <= req_address[1:0];
              we_p0     <= req_write_enable;
              wdata_p0  <= lane_wdata;
              wstrb_p0  <= req_write_enable ? lane_wstrb : 4'b0000;
            end
          end
        end
        ST_REQ: begin
          if (!mem.mem_ready && tmo) resp_p0 <= '0;
        end
        ST_WAIT_RESP: begin
          if (mem.mem_rvalid) resp_p0 <= lane_rdata;
          else if (tmo)       resp_p0 <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

  logic [CNT_W-1:0] tmo_cnt_p0;
  logic             berr_p0;

  assign tmo = ((state == ST_REQ) || (state == ST_WAIT_RESP)) &&
               (tmo_cnt_p0 == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cycles spent in REQ+WAIT_RESP; held at zero while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                              tmo_cnt_p0 <= '0;
    else if (state == ST_IDLE)                              tmo_cnt_p0 <= '0;
    else if ((state == ST_REQ) || (state == ST_WAIT_RESP))  tmo_cnt_p0 <= tmo_cnt_p0 + 1'b1;
  end

  // Remember that the transaction was aborted so DONE can flag it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                               berr_p0 <= 1'b0;
    else if (state == ST_IDLE)                               berr_p0 <= 1'b0;
    else if ((state == ST_REQ) && !mem.mem_ready && tmo)     berr_p0 <= 1'b1;
    else if ((state == ST_WAIT_RESP) && !mem.mem_rvalid && tmo) berr_p0 <= 1'b1;
  end

  assign bus_error = (state == ST_DONE) && berr_p0;
`else
  assign tmo       = 1'b0;
  assign bus_error = 1'b0;
`endif

  assign stall          = ((state == ST_IDLE) && request && !reset) ||
                          (state == ST_REQ) || (state == ST_WAIT_RESP);
  assign misaligned     = (state == ST_DONE) && mis_p0;
  assign resp_read_data = resp_p0;

  assign mem.mem_valid = (state == ST_REQ);
  assign mem.mem_we    = we_p0;
  assign mem.mem_addr  = {addr_p0, 2'b00};
  assign mem.mem_wdata = wdata_p0;
  assign mem.mem_wstrb = wstrb_p0;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed test-plan steps, reset and timeout cases,
// then randomized accesses checked against a byte-lane reference model.
module tb_dmem_bridge;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic        req_read_enable;
  logic        req_write_enable;
  logic [1:0]  req_width;
  logic        stall;
  logic [31:0] resp_read_data;
  logic        misaligned;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  dmem_bridge_if mem ();

  dmem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_address      (req_address),
    .req_write_data   (req_write_data),
    .req_read_enable  (req_read_enable),
    .req_write_enable (req_write_enable),
    .req_width        (req_width),
    .stall            (stall),
    .resp_read_data   (resp_read_data),
    .misaligned       (misaligned),
    .bus_error        (bus_error),
    .mem              (mem)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model: an access of 2**w bytes must start on a multiple of 2**w.
  function automatic logic model_illegal(input logic [1:0] w, input logic [31:0] a);
    if (w == 2'd3) return 1'b1;
    return (a % (32'd1 << w)) != 32'd0;
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] w, input logic [31:0] a);
    int n = 1 << w;
    int m = ((1 << n) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] w, input logic [31:0] wd);
    int n = 1 << w;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] a, input logic [31:0] rd);
    return rd >> (8 * (a % 4));
  endfunction

  // Runs one access from its IDLE cycle to DONE. Entered and left #1 after a
  // rising edge. RAM raises ready after rdy_dly refused REQ cycles and rvalid
  // after rv_dly empty WAIT cycles; stray rvalid is thrown in during REQ.
  task automatic access(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic re, input logic we, input logic [1:0] w,
                        input int rdy_dly, input int rv_dly, input logic [31:0] rd);
    logic        ill;
    int          exp_stall;
    int          stalls, vld, req_cyc, wait_cyc, guard;
    logic        hs, done;
    logic [31:0] hs_addr, hs_wdata;
    logic [3:0]  hs_strb;
    logic        hs_we;
    ill       = model_illegal(w, a);
    exp_stall = ill ? 1 : (we ? 2 + rdy_dly : 3 + rdy_dly + rv_dly);
    stalls = 0; vld = 0; req_cyc = 0; wait_cyc = 0; guard = 0;
    hs = 1'b0; done = 1'b0;
    hs_addr = '0; hs_wdata = '0; hs_strb = '0; hs_we = 1'b0;
    req_address = a; req_write_data = wd; req_read_enable = re;
    req_write_enable = we; req_width = w;
    while (!done && guard < 80) begin
      @(negedge clock);
      guard++;
      mem.mem_ready  = 1'b0;
      mem.mem_rvalid = 1'b0;
      mem.mem_rdata  = $urandom;
      if (!stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (mem.mem_valid) begin
          vld++;
          if (req_cyc == rdy_dly) begin
            mem.mem_ready = 1'b1;
            hs = 1'b1;
            hs_addr = mem.mem_addr; hs_wdata = mem.mem_wdata;
            hs_strb = mem.mem_wstrb; hs_we = mem.mem_we;
          end else if ($urandom_range(0, 1) == 1) begin
            mem.mem_rvalid = 1'b1;
          end
          req_cyc++;
        end else if (hs && !we) begin
          if (wait_cyc == rv_dly) begin
            mem.mem_rvalid = 1'b1;
            mem.mem_rdata  = rd;
          end
          wait_cyc++;
        end
      end
    end
    chk1({tag, " reached_done"}, done, 1'b1);
    chk({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
    chk1({tag, " misaligned"}, misaligned, ill);
    chk1({tag, " bus_error"}, bus_error, 1'b0);
    if (ill) begin
      chk({tag, " valid_cycles"}, 32'(vld), 32'd0);
    end else begin
      chk({tag, " mem_addr"}, hs_addr, {a[31:2], 2'b00});
      chk1({tag, " mem_we"}, hs_we, we);
      chk({tag, " mem_wstrb"}, {28'd0, hs_strb}, we ? {28'd0, model_strb(w, a)} : 32'd0);
      if (we) chk({tag, " mem_wdata"}, hs_wdata, model_wdata(w, wd));
      else    chk({tag, " resp_data"}, resp_read_data, model_rdata(a, rd));
    end
    @(posedge clock);
    #1;
    req_read_enable = 1'b0;
    req_write_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_address = '0; req_write_data = '0; req_read_enable = 1'b0;
    req_write_enable = 1'b0; req_width = 2'd0;
    mem.mem_ready = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;

    // Reset values
    repeat (2) @(negedge clock);
    chk1("rst stall", stall, 1'b0);
    chk1("rst mem_valid", mem.mem_valid, 1'b0);
    chk1("rst mem_we", mem.mem_we, 1'b0);
    chk("rst mem_addr", mem.mem_addr, 32'd0);
    chk("rst mem_wdata", mem.mem_wdata, 32'd0);
    chk("rst mem_wstrb", {28'd0, mem.mem_wstrb}, 32'd0);
    chk("rst resp", resp_read_data, 32'd0);
    chk1("rst misaligned", misaligned, 1'b0);
    chk1("rst bus_error", bus_error, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Test-plan accesses
    access("st_word", 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 2'd2, 0, 0, 32'd0);
    access("st_byte", 32'h103, 32'h000000A5, 1'b0, 1'b1, 2'd0, 0, 0, 32'd0);
    access("ld_half", 32'h202, 32'd0, 1'b1, 1'b0, 2'd1, 2, 2, 32'h1234ABCD);
    chk("ld_half value", resp_read_data, 32'h00001234);
    access("ld_misal", 32'h301, 32'd0, 1'b1, 1'b0, 2'd2, 0, 0, 32'd0);
    access("rw_both", 32'h012, 32'h0000BEEF, 1'b1, 1'b1, 2'd1, 1, 0, 32'd0);
    access("ld_byte", 32'h041, 32'd0, 1'b1, 1'b0, 2'd0, 0, 0, 32'h89ABCDEF);
    access("rsvd_w", 32'h040, 32'd0, 1'b0, 1'b1, 2'd3, 0, 0, 32'd0);

    // Reset during REQ: mem_valid must drop without a clock edge
    req_write_enable = 1'b1; req_width = 2'd2;
    req_address = 32'h500; req_write_data = 32'h11223344;
    @(negedge clock);
    @(negedge clock);
    chk1("rstreq valid_before", mem.mem_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk1("rstreq valid", mem.mem_valid, 1'b0);
    chk1("rstreq stall", stall, 1'b0);
    chk("rstreq wstrb", {28'd0, mem.mem_wstrb}, 32'd0);
    req_write_enable = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;

    // Reset during WAIT_RESP, then a late rvalid that must be ignored
    req_read_enable = 1'b1; req_width = 2'd2; req_address = 32'h400;
    @(negedge clock);
    @(negedge clock);
    mem.mem_ready = 1'b1;
    @(negedge clock);
    mem.mem_ready = 1'b0;
    chk1("rstwait in_wait", stall & ~mem.mem_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk1("rstwait stall", stall, 1'b0);
    chk("rstwait mem_addr", mem.mem_addr, 32'd0);
    chk("rstwait resp", resp_read_data, 32'd0);
    chk1("rstwait misaligned", misaligned, 1'b0);
    req_read_enable = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'hDEADBEEF;
    @(negedge clock);
    mem.mem_rvalid = 1'b0;
    chk1("late_rvalid stall", stall, 1'b0);
    chk("late_rvalid resp", resp_read_data, 32'd0);
    @(posedge clock);
    #1;
    access("after_rst", 32'h404, 32'd0, 1'b1, 1'b0, 2'd2, 1, 1, 32'hCAFEF00D);

`ifdef DMEM_TIMEOUT_EN
    // RAM never answers: abort after TMO cycles in REQ
    begin
      int   stalls, vcnt;
      logic done;
      stalls = 0; vcnt = 0; done = 1'b0;
      req_read_enable = 1'b1; req_width = 2'd2; req_address = 32'h600;
      for (int i = 0; i < 20 && !done; i++) begin
        @(negedge clock);
        if (!stall) done = 1'b1;
        else begin
          stalls++;
          if (mem.mem_valid) vcnt++;
        end
      end
      chk1("tmo reached_done", done, 1'b1);
      chk("tmo stall_cycles", 32'(stalls), 32'(TMO + 1));
      chk("tmo valid_cycles", 32'(vcnt), 32'(TMO));
      chk1("tmo bus_error", bus_error, 1'b1);
      chk1("tmo mem_valid", mem.mem_valid, 1'b0);
      chk("tmo resp", resp_read_data, 32'd0);
      req_read_enable = 1'b0;
      @(negedge clock);
      chk1("tmo pulse_end", bus_error, 1'b0);
      @(posedge clock);
      #1;
    end
`else
    // RAM stalls for a long time: the bridge keeps waiting
    begin
      req_write_enable = 1'b1; req_width = 2'd2;
      req_address = 32'h600; req_write_data = 32'h00000055;
      repeat (12) @(negedge clock);
      chk1("hang stall", stall, 1'b1);
      chk1("hang mem_valid", mem.mem_valid, 1'b1);
      chk1("hang bus_error", bus_error, 1'b0);
      mem.mem_ready = 1'b1;
      @(negedge clock);
      mem.mem_ready = 1'b0;
      chk1("hang done", stall, 1'b0);
      req_write_enable = 1'b0;
      @(posedge clock);
      #1;
    end
`endif

    // Randomized back-to-back accesses
    for (int k = 0; k < 30; k++) begin
      logic [1:0]  w, sel;
      logic [31:0] a;
      w   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a   = $urandom;
      if (w != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << w) - 32'd1);
      sel = 2'($urandom_range(1, 3));
      access("rand", a, $urandom, sel[0], sel[1], w,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
